apb4_master: RTL and testbench

APB4_MASTER -- requirements
Module: apb4_master

---
 rtl/apb4_pkg.sv | 14 +
 rtl/apb4_wait_timer.sv | 31 +++
 rtl/apb4_master.sv | 117 +++++++++++
 tb/tb_apb4_master.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// Shared APB4 definitions: transfer state encoding and default bus widths.
package apb4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb4_state_e;

    localparam int APB4_ADDR_W         = 8;
    localparam int APB4_DATA_W         = 32;
    localparam int APB4_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb4_wait_timer.sv
// Saturating wait-cycle counter for the ACCESS phase; only compiled into
// the design when APB4_MASTER_TIMEOUT_EN is defined.
`ifdef APB4_MASTER_TIMEOUT_EN
module apb4_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(LIMIT));

endmodule
`endif

// File: rtl/apb4_master.sv
// APB4 master: turns a valid/ready command into one SETUP/ACCESS transfer.
// Optional ACCESS timeout is enabled with the APB4_MASTER_TIMEOUT_EN macro.
//
// Handshake: a command transfers on any rising edge where cmd_valid and
// cmd_ready are both high; rsp_valid is a single-cycle completion pulse.
module apb4_master
    import apb4_pkg::*;
#(
    parameter int ADDR_W         = APB4_ADDR_W,
    parameter int DATA_W         = APB4_DATA_W,
    parameter int TIMEOUT_CYCLES = APB4_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output apb4_state_e       state
);

    logic timeout;
    logic done;
    logic accept;

`ifdef APB4_MASTER_TIMEOUT_EN
    logic expired;

    apb4_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == SETUP),
        .enable ((state == ACCESS) && !pready),
        .expired(expired)
    );

    assign timeout = (state == ACCESS) && expired;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    // pready wins over a timeout landing in the same cycle
    assign done      = (state == ACCESS) && (pready || timeout);
    assign cmd_ready = (state == IDLE) || done;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (done) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= pready ? pslverr : 1'b1;
                        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                        if (accept) begin
                            state   <= SETUP;
                            penable <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            psel    <= 1'b0;
                            penable <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master with a cycle-driven slave model in tasks.
module tb_apb4_master;
    import apb4_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    apb4_state_e   state;

    int n_vec;
    int n_err;

    apb4_master #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer; the slave inserts nwait pready=0 cycles in ACCESS.
    task automatic run_xfer(input string tag, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int nwait,
                            input logic [DW-1:0] prd, input logic slv,
                            input int exp_lat, input logic [DW-1:0] exp_rd,
                            input logic exp_err);
        int   lat;
        int   acc;
        logic hold_ok;
        logic got_rsp;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check({tag, "_setup_phase"}, {30'd0, psel, penable}, 32'd2);
        lat     = 0;
        acc     = 0;
        hold_ok = 1'b1;
        got_rsp = 1'b0;
        while (!got_rsp && lat < 40) begin
            if (paddr !== a || pwrite !== w || pwdata !== wd || psel !== 1'b1)
                hold_ok = 1'b0;
            if (psel && penable) begin
                pready  = (acc >= nwait);
                prdata  = prd;
                pslverr = slv;
                acc++;
            end else begin
                pready  = 1'b1;
                prdata  = '0;
                pslverr = 1'b0;
            end
            tick();
            lat++;
            got_rsp = rsp_valid;
        end
        pready  = 1'b1;
        prdata  = '0;
        pslverr = 1'b0;
        check({tag, "_rsp_seen"},  32'(got_rsp), 32'd1);
        check({tag, "_latency"},   32'(lat), 32'(exp_lat));
        check({tag, "_rdata"},     rsp_rdata, exp_rd);
        check({tag, "_err"},       32'(rsp_err), 32'(exp_err));
        check({tag, "_hold"},      32'(hold_ok), 32'd1);
        check({tag, "_idle_psel"}, {30'd0, psel, penable}, 32'd0);
        check({tag, "_idle_st"},   32'(state), 32'(IDLE));
        tick();
        check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",   32'(state), 32'(IDLE));
        check("rst_psel_en", {30'd0, psel, penable}, 32'd0);
        check("rst_pwrite",  32'(pwrite), 32'd0);
        check("rst_paddr",   32'(paddr), 32'd0);
        check("rst_pwdata",  pwdata, 32'd0);
        check("rst_rsp",     {30'd0, rsp_valid, rsp_err}, 32'd0);
        check("rst_rdata",   rsp_rdata, 32'd0);
        check("rst_ready",   32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_xfer("wr_10",   1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0000_0000, 1'b0, 2, 32'h0, 1'b0);
        check("idle_paddr_hold",  32'(paddr), 32'h10);
        check("idle_pwdata_hold", pwdata, 32'hDEADBEEF);
        run_xfer("rd_10_w3", 1'b0, 8'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 5, 32'hDEADBEEF, 1'b0);
        run_xfer("rd_slverr", 1'b0, 8'h2C, 32'h0, 1, 32'h12345678, 1'b1, 3, 32'h12345678, 1'b1);
        run_xfer("wr_slverr", 1'b1, 8'hFF, 32'h0BAD_F00D, 0, 32'h5555_AAAA, 1'b1, 2, 32'h0, 1'b1);

        // back-to-back writes with cmd_valid held high
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h01;
        cmd_wdata = 32'hA1;
        pready    = 1'b1;
        tick();
        check("b2b_setup1", {30'd0, psel, penable}, 32'd2);
        check("b2b_paddr1", 32'(paddr), 32'h01);
        check("b2b_busy",   32'(cmd_ready), 32'd0);
        cmd_addr  = 8'h02;
        cmd_wdata = 32'hA2;
        tick();
        check("b2b_access1",  {30'd0, psel, penable}, 32'd3);
        check("b2b_ignored",  32'(paddr), 32'h01);
        check("b2b_ready",    32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("b2b_setup2",   {30'd0, psel, penable}, 32'd2);
        check("b2b_state2",   32'(state), 32'(SETUP));
        check("b2b_paddr2",   32'(paddr), 32'h02);
        check("b2b_pwdata2",  pwdata, 32'hA2);
        check("b2b_rsp1",     32'(rsp_valid), 32'd1);
        tick();
        check("b2b_access2",  {30'd0, psel, penable}, 32'd3);
        check("b2b_rsp_gap",  32'(rsp_valid), 32'd0);
        tick();
        check("b2b_rsp2",     32'(rsp_valid), 32'd1);
        check("b2b_idle",     32'(state), 32'(IDLE));
        tick();

`ifdef APB4_MASTER_TIMEOUT_EN
        run_xfer("timeout", 1'b0, 8'h44, 32'h0, 1000, 32'hCAFEF00D, 1'b0, 2 + TO, 32'h0, 1'b1);
`endif

        // reset pulse while the slave stalls in ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h33;
        tick();
        cmd_valid = 1'b0;
        pready    = 1'b0;
        tick();
        check("rstx_in_access", 32'(state), 32'(ACCESS));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstx_psel_en", {30'd0, psel, penable}, 32'd0);
        check("rstx_state",   32'(state), 32'(IDLE));
        check("rstx_paddr",   32'(paddr), 32'd0);
        #2;
        rst_n  = 1'b1;
        pready = 1'b1;
        #1;
        check("rstx_ready",   32'(cmd_ready), 32'd1);
        tick();
        check("rstx_no_rsp",  32'(rsp_valid), 32'd0);
        check("rstx_idle",    32'(state), 32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
